dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port A (pipeline MEM stage) and port B (debug/loader unit).
- Per transaction: arbitrates, drives the memory read_write/address/write-data bus for one command cycle, captures read data, and returns a one-cycle ack.
- Out-of-range addresses and illegal command codes are rejected locally and never reach the memory.
- Sits between the MEM stage/debug unit and the data memory. The memory samples commands on negedge clk and holds read data in a register.

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_rr_arbiter2.sv | 31 +++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared command codes, FSM states and port identifiers for the data-memory arbiter.
package dmem_arbiter_pkg;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_READ  = 2'b10;

  localparam int PORT_A = 0;
  localparam int PORT_B = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  function automatic logic rw_legal(input logic [1:0] rw);
    return (rw == RW_WRITE) || (rw == RW_READ);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-way arbiter: round-robin on ties, or A-first when fixed_prio is set.
module rr_arbiter2
  import dmem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       update,
  output logic [1:0] grant
);

  // High when B held the most recent grant, so A wins the next tie.
  logic last_grant_b_reg;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (fixed_prio || last_grant_b_reg) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_b_reg <= 1'b1;
    end else if (update) begin
      last_grant_b_reg <= grant[PORT_B];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (A) and the debug/loader (B).
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH      = 10,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic [1:0]  a_rw,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_req,
  input  logic [1:0]  b_rw,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_err,
  output logic        a_stall,
  output logic [1:0]  mem_read_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_data
);

  state_t      state_reg, state_next;
  logic [1:0]  grant;
  logic        arb_update;
  logic        gnt_b_reg;
  logic        is_read_reg;
  logic [1:0]  sel_rw;
  logic [31:0] sel_addr, sel_wdata;
  logic        sel_ok;
  logic        reject_fire, done_fire;
  logic [1:0]  mem_rw_reg;
  logic [31:0] mem_addr_reg, mem_wdata_reg;

  rr_arbiter2 u_arb (
    .clk        (clk),
    .rst        (rst),
    .req        ({b_req, a_req}),
    .fixed_prio (FIXED_PRIO),
    .update     (arb_update),
    .grant      (grant)
  );

  always_comb begin
    state_next  = state_reg;
    arb_update  = 1'b0;
    reject_fire = 1'b0;
    done_fire   = 1'b0;
    sel_rw      = grant[PORT_B] ? b_rw    : a_rw;
    sel_addr    = grant[PORT_B] ? b_addr  : a_addr;
    sel_wdata   = grant[PORT_B] ? b_wdata : a_wdata;
    sel_ok      = (sel_addr < 32'(DEPTH)) && rw_legal(sel_rw);
    case (state_reg)
      IDLE: begin
        if (|grant) begin
          arb_update = 1'b1;
          // Rejected requests skip ISSUE so the memory never sees them.
          if (sel_ok) begin
            state_next = ISSUE;
          end else begin
            state_next  = RESP;
            reject_fire = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_next = RESP;
        done_fire  = 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      mem_rw_reg    <= RW_IDLE;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      gnt_b_reg     <= 1'b0;
      is_read_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (arb_update) begin
        gnt_b_reg <= grant[PORT_B];
      end
      if (arb_update && sel_ok) begin
        mem_rw_reg    <= sel_rw;
        mem_addr_reg  <= sel_addr;
        mem_wdata_reg <= (sel_rw == RW_WRITE) ? sel_wdata : '0;
        is_read_reg   <= (sel_rw == RW_READ);
      end else if (done_fire) begin
        mem_rw_reg <= RW_IDLE;
      end
    end
  end

  // Per-port response registers; ack pulses for one cycle, rdata only moves on a read ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic        hit;
    logic        ack_reg;
    logic        err_reg;
    logic [31:0] rdata_reg;

    assign hit = reject_fire ? grant[gi]
               : (done_fire && ((gi == PORT_B) ? gnt_b_reg : !gnt_b_reg));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ack_reg   <= 1'b0;
        err_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= hit;
        err_reg <= hit && reject_fire;
        if (hit && done_fire && is_read_reg) begin
          rdata_reg <= mem_data;
        end
      end
    end
  end

  assign a_ack          = g_port[0].ack_reg;
  assign a_err          = g_port[0].err_reg;
  assign a_rdata        = g_port[0].rdata_reg;
  assign b_ack          = g_port[1].ack_reg;
  assign b_err          = g_port[1].err_reg;
  assign b_rdata        = g_port[1].rdata_reg;
  assign a_stall        = a_req && !a_ack;
  assign mem_read_write = mem_rw_reg;
  assign mem_address    = mem_addr_reg;
  assign mem_write_data = mem_wdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench: directed scenarios plus randomized rounds against a transaction-level model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int DEPTH = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_req, b_req;
  logic [1:0]  a_rw, b_rw;
  logic [31:0] a_addr, b_addr, a_wdata, b_wdata;

  logic        a_ack, b_ack, a_err, b_err, a_stall;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  mem_read_write;
  logic [31:0] mem_address, mem_write_data;
  logic [31:0] mem_data = '0;

  logic        f_a_ack, f_b_ack, f_a_err, f_b_err, f_a_stall;
  logic [31:0] f_a_rdata, f_b_rdata;
  logic [1:0]  f_mem_read_write;
  logic [31:0] f_mem_address, f_mem_write_data;
  logic [31:0] f_mem_data = '0;

  logic [31:0] mem0 [16] = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h108,
                             32'h109, 32'h10a, 32'h10b, 32'h10c, 32'h10d, 32'h10e, 32'h10f, 32'h110};
  logic [31:0] mem1 [16] = '{32'h101, 32'h102, 32'h103, 32'h104, 32'h105, 32'h106, 32'h107, 32'h108,
                             32'h109, 32'h10a, 32'h10b, 32'h10c, 32'h10d, 32'h10e, 32'h10f, 32'h110};

  // Reference state: expected memory contents, last rdata per port, last granted port.
  logic [31:0] ref_mem [16];
  logic [31:0] ref_rd [2];
  bit          last_b;
  int          n_checks = 0;
  int          n_fail   = 0;

  dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .a_stall(a_stall),
    .mem_read_write(mem_read_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_data(mem_data)
  );

  dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(f_a_ack), .a_rdata(f_a_rdata), .a_err(f_a_err),
    .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(f_b_ack), .b_rdata(f_b_rdata), .b_err(f_b_err),
    .a_stall(f_a_stall),
    .mem_read_write(f_mem_read_write), .mem_address(f_mem_address),
    .mem_write_data(f_mem_write_data), .mem_data(f_mem_data)
  );

  // Behavioural memories: sample the command on negedge, registered read data.
  always @(negedge clk) begin
    if (mem_read_write == RW_WRITE) mem0[mem_address[3:0]] <= mem_write_data;
    else if (mem_read_write == RW_READ) mem_data <= mem0[mem_address[3:0]];
    if (f_mem_read_write == RW_WRITE) mem1[f_mem_address[3:0]] <= f_mem_write_data;
    else if (f_mem_read_write == RW_READ) f_mem_data <= mem1[f_mem_address[3:0]];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic [1:0] rw, input logic [31:0] ad, input logic [31:0] wd);
    if (p == 0) begin a_rw = rw; a_addr = ad; a_wdata = wd; end
    else        begin b_rw = rw; b_addr = ad; b_wdata = wd; end
  endtask

  function automatic logic [1:0] pick_rw();
    int v;
    v = $urandom_range(0, 9);
    if (v < 4) return RW_WRITE;
    if (v < 8) return RW_READ;
    if (v == 8) return 2'b00;
    return 2'b11;
  endfunction

  task automatic test_reset();
    a_req = 0; b_req = 0;
    set_port(0, RW_IDLE, '0, '0);
    set_port(1, RW_IDLE, '0, '0);
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h101 + 32'(i);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (mem_read_write !== 2'b00) begin n_fail++; $display("FAIL reset_mem_rw: got %b want 00", mem_read_write); end
    n_checks++; if (mem_address !== 32'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_address); end
    n_checks++; if (mem_write_data !== 32'h0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_write_data); end
    n_checks++; if ({a_ack, b_ack, a_err, b_err} !== 4'b0) begin n_fail++; $display("FAIL reset_ack_err: got %b want 0000", {a_ack, b_ack, a_err, b_err}); end
    n_checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h want 0/0", a_rdata, b_rdata); end
    n_checks++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", a_stall); end
    @(negedge clk);
    rst = 1'b1;
    ref_rd[0] = '0; ref_rd[1] = '0; last_b = 1'b1;
    $display("reset: outputs checked");
  endtask

  task automatic test_simultaneous();
    @(negedge clk);
    set_port(0, RW_READ, 32'd3, 32'h0); set_port(1, RW_READ, 32'd6, 32'h0);
    a_req = 1; b_req = 1;
    tick();
    n_checks++; if (mem_read_write !== RW_READ || mem_address !== 32'd3) begin n_fail++; $display("FAIL simul_issue_a: got rw=%b addr=%0d want rw=10 addr=3", mem_read_write, mem_address); end
    tick();
    n_checks++; if (a_ack !== 1'b1 || a_rdata !== ref_mem[3] || b_ack !== 1'b0) begin n_fail++; $display("FAIL simul_ack_a: got a_ack=%b a_rdata=%h b_ack=%b want 1 %h 0", a_ack, a_rdata, b_ack, ref_mem[3]); end
    @(negedge clk); a_req = 0;
    tick();
    n_checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) begin n_fail++; $display("FAIL simul_gap: got a_ack=%b b_ack=%b want 0 0", a_ack, b_ack); end
    tick();
    n_checks++; if (mem_read_write !== RW_READ || mem_address !== 32'd6) begin n_fail++; $display("FAIL simul_issue_b: got rw=%b addr=%0d want rw=10 addr=6", mem_read_write, mem_address); end
    tick();
    n_checks++; if (b_ack !== 1'b1 || b_rdata !== ref_mem[6] || b_err !== 1'b0) begin n_fail++; $display("FAIL simul_ack_b: got b_ack=%b b_rdata=%h b_err=%b want 1 %h 0", b_ack, b_rdata, b_err, ref_mem[6]); end
    @(negedge clk); b_req = 0;
    tick();
    ref_rd[0] = ref_mem[3]; ref_rd[1] = ref_mem[6]; last_b = 1'b1;
    $display("simultaneous: A rd 3 -> %h, B rd 6 -> %h", a_rdata, b_rdata);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    set_port(0, RW_WRITE, 32'd3, 32'hDEADBEEF); a_req = 1;
    tick();
    n_checks++; if (mem_read_write !== RW_WRITE || mem_address !== 32'd3 || mem_write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_issue: got rw=%b addr=%0d data=%h want 01 3 deadbeef", mem_read_write, mem_address, mem_write_data); end
    n_checks++; if (a_ack !== 1'b0 || a_stall !== 1'b1) begin n_fail++; $display("FAIL wr_stall: got ack=%b stall=%b want 0 1", a_ack, a_stall); end
    tick();
    n_checks++; if (a_ack !== 1'b1 || a_err !== 1'b0 || a_stall !== 1'b0 || mem_read_write !== RW_IDLE) begin n_fail++; $display("FAIL wr_ack: got ack=%b err=%b stall=%b rw=%b want 1 0 0 00", a_ack, a_err, a_stall, mem_read_write); end
    n_checks++; if (a_rdata !== ref_rd[0]) begin n_fail++; $display("FAIL wr_rdata_hold: got %h want %h", a_rdata, ref_rd[0]); end
    ref_mem[3] = 32'hDEADBEEF;
    @(negedge clk); a_req = 0;
    tick();
    @(negedge clk);
    set_port(0, RW_READ, 32'd3, 32'h0); a_req = 1;
    tick();
    n_checks++; if (mem_read_write !== RW_READ) begin n_fail++; $display("FAIL rd_issue: got rw=%b want 10", mem_read_write); end
    tick();
    n_checks++; if (a_ack !== 1'b1 || a_rdata !== ref_mem[3] || b_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack: got ack=%b rdata=%h b_ack=%b want 1 %h 0", a_ack, a_rdata, b_ack, ref_mem[3]); end
    @(negedge clk); a_req = 0;
    tick();
    ref_rd[0] = ref_mem[3]; last_b = 1'b0;
    $display("write_read: A wr 3 deadbeef, rd 3 -> %h", a_rdata);
  endtask

  task automatic test_reject();
    @(negedge clk);
    set_port(1, RW_READ, 32'd10, 32'h0); b_req = 1;
    tick();
    n_checks++; if (b_ack !== 1'b1 || b_err !== 1'b1 || mem_read_write !== RW_IDLE) begin n_fail++; $display("FAIL rej_addr: got ack=%b err=%b rw=%b want 1 1 00", b_ack, b_err, mem_read_write); end
    n_checks++; if (b_rdata !== ref_rd[1]) begin n_fail++; $display("FAIL rej_addr_hold: got %h want %h", b_rdata, ref_rd[1]); end
    @(negedge clk); b_req = 0;
    tick();
    n_checks++; if (b_ack !== 1'b0 || mem_read_write !== RW_IDLE) begin n_fail++; $display("FAIL rej_addr_after: got ack=%b rw=%b want 0 00", b_ack, mem_read_write); end
    @(negedge clk);
    set_port(0, 2'b11, 32'd2, 32'h12345678); a_req = 1;
    tick();
    n_checks++; if (a_ack !== 1'b1 || a_err !== 1'b1 || mem_read_write !== RW_IDLE || a_rdata !== ref_rd[0]) begin n_fail++; $display("FAIL rej_cmd: got ack=%b err=%b rw=%b rdata=%h want 1 1 00 %h", a_ack, a_err, mem_read_write, a_rdata, ref_rd[0]); end
    @(negedge clk); a_req = 0;
    tick();
    last_b = 1'b0;
    $display("reject: B addr 10 and A rw=11 rejected");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    set_port(0, RW_READ, 32'd5, 32'h0); a_req = 1;
    tick();
    n_checks++; if (mem_read_write !== RW_READ) begin n_fail++; $display("FAIL midrst_issue: got rw=%b want 10", mem_read_write); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (mem_read_write !== RW_IDLE || mem_address !== 32'h0 || a_ack !== 1'b0 || b_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got rw=%b addr=%h acks=%b%b want 00 0 00", mem_read_write, mem_address, a_ack, b_ack); end
    n_checks++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h/%h want 0/0", a_rdata, b_rdata); end
    ref_rd[0] = '0; ref_rd[1] = '0; last_b = 1'b1;
    @(negedge clk); rst = 1'b1;
    tick();
    n_checks++; if (mem_read_write !== RW_READ || mem_address !== 32'd5) begin n_fail++; $display("FAIL midrst_reissue: got rw=%b addr=%0d want 10 5", mem_read_write, mem_address); end
    tick();
    n_checks++; if (a_ack !== 1'b1 || a_rdata !== ref_mem[5]) begin n_fail++; $display("FAIL midrst_ack: got ack=%b rdata=%h want 1 %h", a_ack, a_rdata, ref_mem[5]); end
    @(negedge clk); a_req = 0;
    tick();
    ref_rd[0] = ref_mem[5]; last_b = 1'b0;
    $display("mid_reset: A rd 5 after reset -> %h", a_rdata);
  endtask

  task automatic test_random(input int rounds);
    bit          rq [2];
    bit          ok [2];
    logic [1:0]  rw [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] exp_rd [2];
    int          ack_at [2];
    int          order [$];
    int          p, end_cyc;
    logic [1:0]  exp_mrw;
    for (int r = 0; r < rounds; r++) begin
      for (int q = 0; q < 2; q++) begin
        rq[q] = 1'($urandom_range(0, 1));
        rw[q] = pick_rw();
        ad[q] = 32'($urandom_range(0, 12));
        wd[q] = $urandom;
        ok[q] = (ad[q] < DEPTH) && (rw[q] == RW_WRITE || rw[q] == RW_READ);
        ack_at[q] = -10;
        exp_rd[q] = ref_rd[q];
      end
      if (!rq[0] && !rq[1]) rq[$urandom_range(0, 1)] = 1'b1;
      order.delete();
      if (rq[0] && rq[1]) begin
        if (last_b) begin order.push_back(0); order.push_back(1); end
        else        begin order.push_back(1); order.push_back(0); end
      end else begin
        order.push_back(rq[0] ? 0 : 1);
      end
      // Each transaction is sampled one cycle after drive, or two after the previous ack.
      end_cyc = 0;
      for (int i = 0; i < order.size(); i++) begin
        p = order[i];
        ack_at[p] = ((i == 0) ? 1 : end_cyc + 2) + (ok[p] ? 1 : 0);
        if (ok[p] && rw[p] == RW_READ) exp_rd[p] = ref_mem[ad[p][3:0]];
        if (ok[p] && rw[p] == RW_WRITE) ref_mem[ad[p][3:0]] = wd[p];
        end_cyc = ack_at[p];
        last_b = (p == 1);
      end
      $display("round %0d: A req=%0d rw=%b addr=%0d | B req=%0d rw=%b addr=%0d | first=%s",
               r, rq[0], rw[0], ad[0], rq[1], rw[1], ad[1], (order[0] == 0) ? "A" : "B");
      @(negedge clk);
      set_port(0, rw[0], ad[0], wd[0]); set_port(1, rw[1], ad[1], wd[1]);
      a_req = rq[0]; b_req = rq[1];
      for (int c = 1; c <= end_cyc + 1; c++) begin
        tick();
        exp_mrw = RW_IDLE;
        for (int q = 0; q < 2; q++) if (rq[q] && ok[q] && c == ack_at[q] - 1) exp_mrw = rw[q];
        n_checks++; if (mem_read_write !== exp_mrw) begin n_fail++; $display("FAIL rnd%0d_c%0d_mem_rw: got %b want %b", r, c, mem_read_write, exp_mrw); end
        n_checks++; if (a_ack !== (rq[0] && c == ack_at[0]) || a_err !== (rq[0] && c == ack_at[0] && !ok[0])) begin
          n_fail++; $display("FAIL rnd%0d_c%0d_a_ack: got ack=%b err=%b want ack=%b err=%b", r, c, a_ack, a_err, rq[0] && c == ack_at[0], rq[0] && c == ack_at[0] && !ok[0]);
        end
        n_checks++; if (b_ack !== (rq[1] && c == ack_at[1]) || b_err !== (rq[1] && c == ack_at[1] && !ok[1])) begin
          n_fail++; $display("FAIL rnd%0d_c%0d_b_ack: got ack=%b err=%b want ack=%b err=%b", r, c, b_ack, b_err, rq[1] && c == ack_at[1], rq[1] && c == ack_at[1] && !ok[1]);
        end
        n_checks++; if (a_rdata !== ((rq[0] && c >= ack_at[0]) ? exp_rd[0] : ref_rd[0])) begin n_fail++; $display("FAIL rnd%0d_c%0d_a_rdata: got %h want %h", r, c, a_rdata, (rq[0] && c >= ack_at[0]) ? exp_rd[0] : ref_rd[0]); end
        n_checks++; if (b_rdata !== ((rq[1] && c >= ack_at[1]) ? exp_rd[1] : ref_rd[1])) begin n_fail++; $display("FAIL rnd%0d_c%0d_b_rdata: got %h want %h", r, c, b_rdata, (rq[1] && c >= ack_at[1]) ? exp_rd[1] : ref_rd[1]); end
        n_checks++; if (a_stall !== (a_req && !(rq[0] && c == ack_at[0]))) begin n_fail++; $display("FAIL rnd%0d_c%0d_a_stall: got %b want %b", r, c, a_stall, a_req && !(rq[0] && c == ack_at[0])); end
        @(negedge clk);
        if (rq[0] && c == ack_at[0]) a_req = 0;
        if (rq[1] && c == ack_at[1]) b_req = 0;
        // The in-flight port's inputs were latched at grant; later wiggles must not matter.
        if (c < ack_at[order[0]]) set_port(order[0], pick_rw(), 32'($urandom_range(0, 12)), $urandom);
      end
      for (int q = 0; q < 2; q++) if (rq[q]) ref_rd[q] = exp_rd[q];
    end
  endtask

  task automatic test_fixed_prio();
    int f_a_count;
    int port;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    ref_rd[0] = '0; ref_rd[1] = '0; last_b = 1'b1;
    set_port(0, RW_READ, 32'd1, 32'h0); set_port(1, RW_READ, 32'd2, 32'h0);
    a_req = 1; b_req = 1;
    f_a_count = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (f_a_ack === 1'b1) f_a_count++;
      n_checks++; if (f_b_ack !== 1'b0) begin n_fail++; $display("FAIL fixed_b_starved_k%0d: got f_b_ack=%b want 0", k, f_b_ack); end
      port = -1;
      if (k % 3 == 2) begin port = last_b ? 0 : 1; last_b = (port == 1); end
      n_checks++; if (a_ack !== (port == 0) || b_ack !== (port == 1)) begin n_fail++; $display("FAIL rr_alternate_k%0d: got a_ack=%b b_ack=%b want %b %b", k, a_ack, b_ack, port == 0, port == 1); end
      if (port == 0) begin
        n_checks++; if (a_rdata !== ref_mem[1]) begin n_fail++; $display("FAIL rr_a_rdata_k%0d: got %h want %h", k, a_rdata, ref_mem[1]); end
      end
      if (port == 1) begin
        n_checks++; if (b_rdata !== ref_mem[2]) begin n_fail++; $display("FAIL rr_b_rdata_k%0d: got %h want %h", k, b_rdata, ref_mem[2]); end
      end
    end
    n_checks++; if (f_a_count != 5) begin n_fail++; $display("FAIL fixed_a_count: got %0d want 5", f_a_count); end
    @(negedge clk); a_req = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++; if (f_b_ack !== (k == 2) || b_ack !== (k == 2)) begin n_fail++; $display("FAIL fixed_b_after_a_k%0d: got f_b_ack=%b b_ack=%b want %b", k, f_b_ack, b_ack, k == 2); end
    end
    b_req = 0;
    $display("fixed_prio: A acks=%0d while held, B served after A dropped", f_a_count);
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_write_read();
    test_reject();
    test_mid_reset();
    test_random(40);
    test_fixed_prio();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
